// File: rtl/apb_slave_ctrl_pkg.sv
// ============================================================================
// Module      : apb_slave_ctrl_pkg
// Description : APB phase FSM encoding, shared with the register block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_slave_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SETUP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;

endpackage : apb_slave_ctrl_pkg

`default_nettype wire

// File: rtl/apb_slave_ctrl.sv
// ============================================================================
// Module      : apb_slave_ctrl
// Description : Zero-wait-state APB slave controller: phase FSM plus
//               combinational ready/error/strobe decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_ctrl
    import apb_slave_ctrl_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic tim_psel,
    input  logic tim_pwrite,
    input  logic tim_penable,
    input  logic reg_error_flag,
    output logic tim_pready,
    output logic tim_pslverr,
    output logic wr_en,
    output logic rd_en
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               w_access_valid;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (tim_psel && !tim_penable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (!tim_psel)        state_d = ST_IDLE;
                else if (tim_penable) state_d = ST_ACCESS;
                else                  state_d = ST_SETUP;
            end
            ST_ACCESS: begin
                // A fresh SETUP straight out of ACCESS is a back-to-back transfer.
                if (tim_psel && !tim_penable) state_d = ST_SETUP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the first ACCESS cycle (FSM still in SETUP) is a valid access,
    // so held or out-of-protocol penable never produces a second strobe.
    assign w_access_valid = (state_q == ST_SETUP) && tim_psel && tim_penable;

    assign tim_pready  = w_access_valid;
    assign tim_pslverr = w_access_valid && reg_error_flag;
    assign wr_en       = w_access_valid && tim_pwrite;
    assign rd_en       = w_access_valid && !tim_pwrite;

endmodule : apb_slave_ctrl

`default_nettype wire

// File: tb/tb_apb_slave_ctrl.sv
// ============================================================================
// Module      : tb_apb_slave_ctrl
// Description : Directed self-checking bench for apb_slave_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic tim_psel = 1'b0;
    logic tim_pwrite = 1'b0;
    logic tim_penable = 1'b0;
    logic reg_error_flag = 1'b0;
    logic tim_pready;
    logic tim_pslverr;
    logic wr_en;
    logic rd_en;

    int checks = 0;
    int errors = 0;

    // Output vector order: {pready, pslverr, wr_en, rd_en}
    wire [3:0] outs = {tim_pready, tim_pslverr, wr_en, rd_en};

    apb_slave_ctrl u_dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .tim_psel       (tim_psel),
        .tim_pwrite     (tim_pwrite),
        .tim_penable    (tim_penable),
        .reg_error_flag (reg_error_flag),
        .tim_pready     (tim_pready),
        .tim_pslverr    (tim_pslverr),
        .wr_en          (wr_en),
        .rd_en          (rd_en)
    );

    always #5 sys_clk = ~sys_clk;

    // Apply bus inputs on the falling edge and let them settle before sampling.
    task automatic drive(input logic psel, input logic pwrite,
                         input logic penable, input logic err);
        @(negedge sys_clk);
        tim_psel       = psel;
        tim_pwrite     = pwrite;
        tim_penable    = penable;
        reg_error_flag = err;
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL write_setup: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b1010) begin
            errors++;
            $display("FAIL write_access: got %b expected %b", outs, 4'b1010);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL write_after: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_read();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b1001) begin
            errors++;
            $display("FAIL read_access: got %b expected %b", outs, 4'b1001);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL read_after: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_error();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL err_in_setup_ignored: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (outs !== 4'b1110) begin
            errors++;
            $display("FAIL write_error: got %b expected %b", outs, 4'b1110);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL err_idle_ignored: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (outs !== 4'b1101) begin
            errors++;
            $display("FAIL read_error: got %b expected %b", outs, 4'b1101);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs: got %b expected %b", outs, 4'b0000);
        end
        // Back in IDLE, an ACCESS without SETUP must stay silent.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL abort_back_to_idle: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_setup_hold();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL setup_hold_quiet: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b1001) begin
            errors++;
            $display("FAIL setup_hold_read: got %b expected %b", outs, 4'b1001);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_penable_held();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b1010;
        exp_seq[1] = 4'b0000;
        exp_seq[2] = 4'b0000;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++;
                $display("FAIL penable_held_cycle%0d: got %b expected %b", i, outs, exp_seq[i]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_first_write: got %b expected %b", outs, 4'b1010);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_second_setup: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b1001) begin
            errors++;
            $display("FAIL b2b_second_read: got %b expected %b", outs, 4'b1001);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (outs !== 4'b1110) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b expected %b", outs, 4'b1110);
        end
        #1 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_immediate: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL rst_release_no_setup: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (outs !== 4'b0000) begin
            errors++;
            $display("FAIL rst_release_no_setup2: got %b expected %b", outs, 4'b0000);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_abort();
        test_setup_hold();
        test_penable_held();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_apb_slave_ctrl

`default_nettype wire

// File: doc/apb_slave_ctrl.md
APB_SLAVE_CTRL -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset: reset is asynchronous and active-low.
REQ-002 sys_clk  input  1  system clock; all state changes on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 tim_psel  input  1  APB select.
REQ-005 tim_pwrite  input  1  APB direction: 1 = write, 0 = read.
REQ-006 tim_penable  input  1  APB enable; marks the ACCESS phase.
REQ-007 reg_error_flag  input  1  error from the register block for the current address/data, valid in the ACCESS cycle.
REQ-008 tim_pready  output  1  transfer complete.
REQ-009 tim_pslverr  output  1  transfer error, valid only while tim_pready=1.
REQ-010 wr_en  output  1  register-block write strobe.
REQ-011 rd_en  output  1  register-block read strobe.
REQ-012 No parameters; all widths fixed at 1.

Function
REQ-013 SHALL track the APB phase with a registered FSM: IDLE, SETUP, ACCESS.
REQ-014 Transitions at rising edge:
- IDLE->SETUP when psel=1 and penable=0.
- SETUP->ACCESS when psel=1 and penable=1.
- SETUP->IDLE when psel=0.
- SETUP stays SETUP when psel=1 and penable=0.
- ACCESS->SETUP when psel=1 and penable=0 (back-to-back transfer).
- ACCESS->IDLE otherwise.
REQ-015 access_valid SHALL equal state==SETUP AND psel=1 AND penable=1, computed combinationally in the same cycle.
REQ-016 Transfers SHALL be zero-wait-state: tim_pready=access_valid, high in the first ACCESS cycle with no added latency.
REQ-017 wr_en SHALL equal access_valid AND pwrite, and rd_en SHALL equal access_valid AND NOT pwrite; each is a single-cycle pulse per transfer.
REQ-018 tim_pslverr SHALL equal access_valid AND reg_error_flag; it is never high while tim_pready=0.
REQ-019 On error, wr_en/rd_en SHALL still assert; the register block suppresses the update.
REQ-020 Aborted transfer: if psel drops before penable rises, the FSM SHALL return to IDLE and no output asserts.
REQ-021 penable=1 with psel=1 in IDLE or ACCESS (protocol violation) SHALL NOT assert any output.
REQ-022 If penable is held high beyond one cycle, the outputs SHALL assert only in the first cycle.
REQ-023 reg_error_flag outside access_valid SHALL be ignored.

Reset
REQ-024 While sys_rst_n=0, the FSM SHALL be IDLE asynchronously and tim_pready, tim_pslverr, wr_en and rd_en SHALL all be 0, regardless of the bus inputs.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer; after release, a new SETUP phase is required.

Structure
REQ-026 The FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, 2 bits) SHALL be localparams in a shared timer package used by the register block.
REQ-027 SHALL be a single module with no sub-modules, consisting of one state register and combinational output decode.

Verification
REQ-028 Write: SETUP (psel=1, pwrite=1), then ACCESS (penable=1) -> in the ACCESS cycle pready=1, wr_en=1, rd_en=0, pslverr=0.
REQ-029 Read: SETUP (psel=1, pwrite=0), then ACCESS -> pready=1, rd_en=1, wr_en=0, pslverr=0.
REQ-030 Write with reg_error_flag=1 -> pready=1, pslverr=1, wr_en=1.
REQ-031 Abort: psel=1 for one cycle, then psel=0 with penable=0 -> pready, wr_en, rd_en and pslverr stay 0; state returns to IDLE.
REQ-032 penable held high for 3 cycles after SETUP -> pready/wr_en high for exactly 1 cycle.
REQ-033 sys_rst_n pulled low during ACCESS -> all outputs 0 immediately; after release, penable=1 without a SETUP phase produces no pready.
